// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction_fetch: holds the architectural PC,
// selects the next PC (sequential / branch / jump / jump-register / stall),
// and traps into a sticky fault state on misaligned or out-of-range targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES   = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc4,
    input  logic [15:0] branch_offset,
    input  logic        jump_valid,
    input  logic [25:0] jump_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic [31:0] current_address,
    output logic [31:0] pc_plus4,
    output logic        pc_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int unsigned PC_W   = 32;
    // Highest address whose full word still lies inside instruction memory
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_fault;
    logic [PC_W-1:0] r_fault_addr;

    state_t          w_next_state;
    logic [PC_W-1:0] w_next_pc;
    logic            w_next_fault;
    logic [PC_W-1:0] w_next_fault_addr;

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_jump_pc;
    logic [PC_W-1:0] w_branch_pc;
    logic [PC_W-1:0] w_sel_pc;
    logic            w_sel_illegal;

    // Candidate targets; all arithmetic wraps modulo 2^32
    assign w_pc_plus4  = r_pc + PC_W'(4);
    assign w_jump_pc   = {w_pc_plus4[31:28], jump_target, 2'b00};
    assign w_branch_pc = branch_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

    // Strict-priority next-PC select; any redirect beats stall
    always_comb begin
        w_sel_pc = w_pc_plus4;
        if (jr_valid) begin
            w_sel_pc = jr_addr;
        end else if (jump_valid) begin
            w_sel_pc = w_jump_pc;
        end else if (branch_taken) begin
            w_sel_pc = w_branch_pc;
        end else if (stall) begin
            w_sel_pc = r_pc;
        end
    end

    assign w_sel_illegal = (w_sel_pc[1:0] != 2'b00) || (w_sel_pc > PC_MAX);

    // State register and PC / fault capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_fault      <= w_next_fault;
            r_fault_addr <= w_next_fault_addr;
        end
    end

    // Next-state logic; HALTED and FAULT only leave through reset
    always_comb begin
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_fault      = r_fault;
        w_next_fault_addr = r_fault_addr;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    w_next_state = ST_HALTED;
                end else if (w_sel_illegal) begin
                    w_next_state      = ST_FAULT;
                    w_next_fault      = 1'b1;
                    w_next_fault_addr = w_sel_pc;
                end else begin
                    w_next_pc = w_sel_pc;
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

    assign current_address = r_pc;
    assign pc_plus4        = w_pc_plus4;
    assign pc_valid        = (r_state == ST_RUN);
    assign fault           = r_fault;
    assign fault_addr      = r_fault_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model predicts each cycle's
// outputs when inputs are driven; the prediction is popped and compared after
// the clock edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc4;
    logic [15:0] branch_offset;
    logic        jump_valid;
    logic [25:0] jump_target;
    logic        jr_valid;
    logic [31:0] jr_addr;
    logic        halt;
    logic [31:0] current_address;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        fault;
    logic [31:0] fault_addr;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .IMEM_BYTES  (28)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_pc4     (branch_pc4),
        .branch_offset  (branch_offset),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .jr_valid       (jr_valid),
        .jr_addr        (jr_addr),
        .halt           (halt),
        .current_address(current_address),
        .pc_plus4       (pc_plus4),
        .pc_valid       (pc_valid),
        .fault          (fault),
        .fault_addr     (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        flt;
        logic [31:0] faddr;
    } exp_t;

    exp_t q_exp[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 boot, 1 run, 2 halted, 3 fault
    int          m_state;
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_faddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_pc4 = 0; branch_offset = 0;
        jump_valid = 0; jump_target = 0; jr_valid = 0; jr_addr = 0; halt = 0;
    endtask

    // Advance the model by one clock using the current inputs
    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] sel;
        logic [31:0] off;
        p4  = m_pc + 32'd4;
        off = 32'($signed(branch_offset)) * 32'd4;
        if (jr_valid)          sel = jr_addr;
        else if (jump_valid)   sel = {p4[31:28], jump_target, 2'b00};
        else if (branch_taken) sel = branch_pc4 + off;
        else if (stall)        sel = m_pc;
        else                   sel = p4;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (halt) begin
                m_state = 2;
            end else if (sel[1:0] != 2'b00 || sel > 32'd24) begin
                m_state = 3;
                m_fault = 1'b1;
                m_faddr = sel;
            end else begin
                m_pc = sel;
            end
        end
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, "_pc"},    current_address, e.pc);
        check({tag, "_p4"},    pc_plus4, e.pc + 32'd4);
        check({tag, "_valid"}, 32'(pc_valid), 32'(e.valid));
        check({tag, "_fault"}, 32'(fault), 32'(e.flt));
        check({tag, "_faddr"}, fault_addr, e.faddr);
    endtask

    // Drive current inputs for one cycle: push prediction, clock, pop and compare
    task automatic step(input string tag);
        exp_t e;
        model_step();
        e.pc = m_pc; e.valid = (m_state == 1); e.flt = m_fault; e.faddr = m_faddr;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            compare_outputs(tag, e);
        end
        idle_inputs();
    endtask

    // Async reset: outputs must return to reset values without a clock edge
    task automatic do_reset(input string tag);
        exp_t e;
        rst_n = 1'b0;
        #1;
        m_state = 0; m_pc = 32'd0; m_fault = 1'b0; m_faddr = 32'd0;
        e.pc = 32'd0; e.valid = 1'b0; e.flt = 1'b0; e.faddr = 32'd0;
        compare_outputs(tag, e);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_outputs({tag, "_boot"}, e);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        do_reset("rst0");

        // BOOT ignores redirects
        jr_valid = 1; jr_addr = 32'd12;
        step("boot_ign");
        check("boot_pc0", current_address, 32'd0);

        // Sequential run
        step("seq4");
        step("seq8");
        check("seq8_const", current_address, 32'd8);
        stall = 1; step("stall1");
        stall = 1; step("stall2");
        check("stall_hold", current_address, 32'd8);
        step("seq12");
        step("seq16");

        // Backward branch beats stall: 16 + (-4*4) = 0
        branch_taken = 1; branch_pc4 = 32'd16; branch_offset = 16'hFFFC; stall = 1;
        step("br_back");
        check("br_back_const", current_address, 32'd0);

        // jr beats jump and branch in the same cycle
        jr_valid = 1; jr_addr = 32'd4; jump_valid = 1; jump_target = 26'h5;
        branch_taken = 1; branch_pc4 = 32'd8; branch_offset = 16'd2;
        step("jr_prio");
        check("jr_prio_const", current_address, 32'd4);

        // Jump beats branch: target 5 -> 20
        jump_valid = 1; jump_target = 26'h5; branch_taken = 1; branch_pc4 = 32'd0;
        branch_offset = 16'd1;
        step("jump");
        check("jump_const", current_address, 32'd20);

        step("seq24");
        // 24 + 4 = 28 is past the end of memory
        step("oor");
        check("oor_faddr", fault_addr, 32'd28);
        check("oor_pc", current_address, 32'd24);
        jr_valid = 1; jr_addr = 32'd0;
        step("fault_sticky");

        // Misaligned jump-register target
        do_reset("rst1");
        step("boot1");
        jr_valid = 1; jr_addr = 32'h6;
        step("misalign");
        check("misalign_faddr", fault_addr, 32'h6);

        // Wrap-around target is out of range
        do_reset("rst2");
        step("boot2");
        jr_valid = 1; jr_addr = 32'hFFFF_FFFC;
        step("wrap");

        // Halt beats a same-cycle jump, then reset mid-HALTED
        do_reset("rst3");
        step("boot3");
        step("seq4b");
        halt = 1; jump_valid = 1; jump_target = 26'h2;
        step("halt");
        check("halt_pc", current_address, 32'd4);
        step("halted_hold");
        #2;
        do_reset("rst_mid");
        step("boot4");
        step("seq4c");

        if (q_exp.size() != 0) check("queue_drain", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
